i2s_dac_bridge: RTL
===================

Name: i2s_dac_bridge

Overview:
- Parametrised successor to the I2S-to-DAC82002 path: receives stereo I2S audio and writes each channel sample to a dual-channel DAC over a 24-bit SPI-style frame (command byte + data).
- Everything runs on the single mck_i domain. bck_i, lrck_i and data_i are oversampled rather than used as clocks.
- Adds over the previous generation: configurable slot and DAC widths, truncation, selectable offset-binary conversion, programmable SCLK rate, a per-channel pending queue and overrun reporting.

Parameters:
- SAMPLE_BITS, 24, bits captured per I2S slot, MSB first (16..32).
- DAC_BITS, 16, DAC data field width; the top DAC_BITS of the captured sample are used (DAC_BITS <= SAMPLE_BITS).
- CMD_BITS, 8, width of the command field.
- LEFT_CMD, 8'h08, command byte for left-channel writes.
- RIGHT_CMD, 8'h09, command byte for right-channel writes.
- OFFSET_BINARY, 1, 1 = invert the data MSB (two's complement to offset binary); 0 = pass through.
- SCLK_DIV, 2, mck_i cycles per SCLK half-period (>= 1).

Ports:
- mck_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- bck_i  in  1  I2S bit clock; asynchronous, must be <= mck_i/4.
- lrck_i  in  1  I2S word select; low = left, high = right.
- data_i  in  1  I2S serial data.
- sdo  out  1  DAC serial data.
- sync  out  1  DAC frame select, active low.
- sclk  out  1  DAC serial clock; idles high.
- sample_valid_o  out  1  one-cycle pulse when a channel sample is captured.
- overrun_o  out  1  one-cycle pulse when a pending, unsent sample is overwritten.
- busy_o  out  1  high while an SPI frame or inter-frame gap is in progress.

Behaviour:
- Reset: sdo=0, sync=1, sclk=1, sample_valid_o=0, overrun_o=0, busy_o=0. Pending flags cleared, holding registers 0, synchronisers 0, receiver and writer both in IDLE. A reset asserted mid-frame drives sync high on the next edge and the frame is abandoned.
- Input sync: 2-flop synchroniser on each of bck_i, lrck_i, data_i. A bck rise is detected as sync'd bck = 1 with previous = 0; lrck and data are sampled on that rise.
- Slot start: an lrck change seen at a bck rise arms the slot. Standard I2S one-bit delay applies: capture begins at the next bck rise.
- Capture: SAMPLE_BITS bits shift in MSB first; extra bits in the slot are ignored.
- Short slot: if lrck toggles before SAMPLE_BITS bits are captured, the partial sample is discarded and capture restarts for the new channel.
- Completion: on the final bit, the channel is latched from lrck at slot start.
  - data = captured[SAMPLE_BITS-1 -: DAC_BITS], with the MSB inverted when OFFSET_BINARY=1.
  - data is written to that channel's holding register, its pending flag is set, and sample_valid_o pulses.
- Overrun: if the channel's pending flag is already set, the new data overwrites the register and overrun_o pulses in the same cycle.
- Writer FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE -> LOAD: when any pending flag is set. If both are set, left goes first. The frame is loaded as {cmd, data} (CMD_BITS+DAC_BITS bits) and the chosen pending flag is cleared in that cycle.
- LOAD -> SHIFT (1 cycle): sync=0 and sdo=frame MSB. busy_o is high from LOAD through GAP.
- SHIFT:
  - sclk falls after SCLK_DIV cycles (the DAC samples on this edge), then rises after another SCLK_DIV cycles.
  - sdo updates to the next bit on each rising edge.
  - After the final falling edge and the following rise, go to GAP with sync=1 and sdo=0.
- GAP: hold sync high for 2*SCLK_DIV cycles, then return to IDLE.
- Frame length: with defaults, one frame is 24 SCLK periods, i.e. 1 + 96 + 4 = 101 mck_i cycles including the gap.
- Simultaneous events: a capture completing in the same cycle as LOAD clears the other channel's flag normally. If it targets the channel being loaded, the flag ends set: the new sample is queued and no overrun is reported.

Test Plan:
- Reset then idle -> sync=1, sclk=1, sdo=0, busy_o=0, and no pulses for 1000 cycles.
- Defaults; left slot 0x123456, right slot 0xFEDCBA -> frame 0x08923 4 sent first, then 0x097EDC. sample_valid_o pulses twice, overrun_o stays 0.
- OFFSET_BINARY=0; left slot 0x800000 -> frame 0x088000. Check SCLK high and low phases are exactly 2 mck each, and sdo is stable across every falling edge.
- SCLK_DIV=8 with bck at mck/4 -> frames fall behind captures; overrun_o pulses on the second unsent left sample, and the latest value is the one transmitted.
- lrck toggles after 10 bits of a slot -> no sample_valid_o and no frame for that slot; the next complete slot is captured correctly.
- rst_i asserted at bit 12 of a frame -> sync=1 on the next cycle and all outputs at reset values; normal operation resumes after release.

Source files
------------

// File: rtl/i2s_dac_bridge.sv
// i2s_dac_bridge: oversampling I2S receiver that forwards each captured channel sample to a
// dual-channel DAC as a {command, data} SPI-style frame. Everything runs on mck_i.
//
// Ports:
//   mck_i          system clock, all logic on its rising edge
//   rst_i          synchronous active-high reset
//   bck_i          I2S bit clock (oversampled, <= mck_i/4)
//   lrck_i         I2S word select, low = left, high = right
//   data_i         I2S serial data, MSB first, one bck after the lrck change
//   sdo            DAC serial data, changes on sclk rising edges
//   sync           DAC frame select, active low
//   sclk           DAC serial clock, idles high, DAC samples on the falling edge
//   sample_valid_o one-cycle pulse per captured channel sample
//   overrun_o      one-cycle pulse when a pending unsent sample is overwritten
//   busy_o         high while a frame (load, shift or gap) is in progress
module i2s_dac_bridge #(
  parameter int unsigned         SAMPLE_BITS   = 24,
  parameter int unsigned         DAC_BITS      = 16,
  parameter int unsigned         CMD_BITS      = 8,
  parameter logic [CMD_BITS-1:0] LEFT_CMD      = 8'h08,
  parameter logic [CMD_BITS-1:0] RIGHT_CMD     = 8'h09,
  parameter bit                  OFFSET_BINARY = 1'b1,
  parameter int unsigned         SCLK_DIV      = 2
) (
  input  logic mck_i,
  input  logic rst_i,
  input  logic bck_i,
  input  logic lrck_i,
  input  logic data_i,
  output logic sdo,
  output logic sync,
  output logic sclk,
  output logic sample_valid_o,
  output logic overrun_o,
  output logic busy_o
);

  localparam int unsigned FRAME_BITS = CMD_BITS + DAC_BITS;
  localparam int unsigned SCW        = $clog2(SAMPLE_BITS);
  localparam int unsigned FCW        = $clog2(FRAME_BITS);
  localparam int unsigned DCW        = $clog2(2 * SCLK_DIV) + 1;

  typedef enum logic {RxIdle, RxCapture} rx_state_e;
  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} wr_state_e;

  logic [1:0] bck_sync_q, lrck_sync_q, data_sync_q;
  logic       bck_prev_q;
  logic       bck_s, lrck_s, data_s, bck_rise;

  rx_state_e              rx_state_q, rx_state_d;
  logic                   lrck_last_q, lrck_last_d;
  logic                   rx_ch_q, rx_ch_d;
  logic [SCW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [SAMPLE_BITS-2:0] rx_shift_q, rx_shift_d;
  logic [SAMPLE_BITS-1:0] captured;
  logic [DAC_BITS-1:0]    rx_data;
  logic                   rx_done;

  logic [DAC_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                valid_q, valid_d, overrun_q, overrun_d;
  logic                load_l, load_r;

  wr_state_e             wr_state_q, wr_state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FCW-1:0]        bit_q, bit_d;
  logic [DCW-1:0]        div_q, div_d;
  logic                  sclk_q, sclk_d, sync_q, sync_d, sdo_q, sdo_d;

  assign bck_s    = bck_sync_q[1];
  assign lrck_s   = lrck_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign bck_rise = bck_s & ~bck_prev_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    lrck_last_d = lrck_last_q;
    rx_ch_d     = rx_ch_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    wr_state_d  = wr_state_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    sync_d      = sync_q;
    sdo_d       = sdo_q;

    // Receiver: an lrck change (re)arms the slot, so a short slot is simply dropped.
    captured = {rx_shift_q, data_s};
    if (bck_rise) begin
      lrck_last_d = lrck_s;
      if (lrck_s != lrck_last_q) begin
        rx_state_d = RxCapture;
        rx_ch_d    = lrck_s;
        rx_cnt_d   = '0;
      end else if (rx_state_q == RxCapture) begin
        rx_shift_d = captured[SAMPLE_BITS-2:0];
        rx_cnt_d   = rx_cnt_q + SCW'(1);
        if (rx_cnt_q == SCW'(SAMPLE_BITS - 1)) begin
          rx_done    = 1'b1;
          rx_state_d = RxIdle;
        end
      end
    end
    rx_data = captured[SAMPLE_BITS-1 -: DAC_BITS];
    if (OFFSET_BINARY) rx_data[DAC_BITS-1] = ~rx_data[DAC_BITS-1];

    // Left has priority; the flag is cleared in the same cycle the frame is latched.
    load_l = (wr_state_q == StIdle) && pend_l_q;
    load_r = (wr_state_q == StIdle) && !pend_l_q && pend_r_q;
    if (load_l) pend_l_d = 1'b0;
    if (load_r) pend_r_d = 1'b0;

    // A capture landing on the channel being loaded is queued, not an overrun.
    if (rx_done) begin
      valid_d = 1'b1;
      if (!rx_ch_q) begin
        hold_l_d  = rx_data;
        pend_l_d  = 1'b1;
        overrun_d = pend_l_q & ~load_l;
      end else begin
        hold_r_d  = rx_data;
        pend_r_d  = 1'b1;
        overrun_d = pend_r_q & ~load_r;
      end
    end

    unique case (wr_state_q)
      StIdle: begin
        if (load_l || load_r) begin
          frame_d    = load_l ? {LEFT_CMD, hold_l_q} : {RIGHT_CMD, hold_r_q};
          wr_state_d = StLoad;
        end
      end
      StLoad: begin
        sync_d     = 1'b0;
        sdo_d      = frame_q[FRAME_BITS-1];
        sclk_d     = 1'b1;
        div_d      = '0;
        bit_d      = '0;
        wr_state_d = StShift;
      end
      StShift: begin
        if (div_q == DCW'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else begin
            sclk_d = 1'b1;
            if (bit_q == FCW'(FRAME_BITS - 1)) begin
              sync_d     = 1'b1;
              sdo_d      = 1'b0;
              wr_state_d = StGap;
            end else begin
              bit_d   = bit_q + FCW'(1);
              frame_d = frame_q << 1;
              sdo_d   = frame_q[FRAME_BITS-2];
            end
          end
        end else begin
          div_d = div_q + DCW'(1);
        end
      end
      StGap: begin
        if (div_q == DCW'(2 * SCLK_DIV - 1)) begin
          div_d      = '0;
          wr_state_d = StIdle;
        end else begin
          div_d = div_q + DCW'(1);
        end
      end
      default: wr_state_d = StIdle;
    endcase
  end

  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bck_prev_q  <= 1'b0;
      rx_state_q  <= RxIdle;
      lrck_last_q <= 1'b0;
      rx_ch_q     <= 1'b0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      pend_l_q    <= 1'b0;
      pend_r_q    <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      wr_state_q  <= StIdle;
      frame_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      sclk_q      <= 1'b1;
      sync_q      <= 1'b1;
      sdo_q       <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[0], bck_i};
      lrck_sync_q <= {lrck_sync_q[0], lrck_i};
      data_sync_q <= {data_sync_q[0], data_i};
      bck_prev_q  <= bck_s;
      rx_state_q  <= rx_state_d;
      lrck_last_q <= lrck_last_d;
      rx_ch_q     <= rx_ch_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      wr_state_q  <= wr_state_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      sync_q      <= sync_d;
      sdo_q       <= sdo_d;
    end
  end

  assign sdo            = sdo_q;
  assign sync           = sync_q;
  assign sclk           = sclk_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = (wr_state_q != StIdle);

endmodule
